nd_pkt_sched: RTL and testbench
===============================

Name: nd_pkt_sched

Overview:
- Packet-level write scheduler for the non-data packet FIFO (8-bit bytes, 50 entries).
- Arbitrates between two requesters: port 0 is the token/handshake decoder, port 1 is the local handshake generator (ACK/NAK/STALL).
- Each packet (1..3 bytes) is written atomically and back-to-back into the FIFO.
- A grant is issued only when the FIFO has room for the whole packet, so packets never interleave or split.

Parameters:
- DEPTH, 50, FIFO entry count; must match the instantiated FIFO depth.
- DATA_W, 8, byte width.
- LEN_W, 2, packet length field width; legal lengths are 1..3.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- req  in  2  per-source packet request; held until that source's pkt_done.
- len0, len1  in  LEN_W  packet byte count per source; sampled at grant.
- data0, data1  in  DATA_W  current byte per source; source advances it on byte_ack.
- byte_ack  out  2  one-hot; byte of that source written this cycle.
- pkt_done  out  2  one-hot pulse on the cycle the last byte is written.
- fifo_w_enable  out  1  to FIFO w_enable.
- fifo_w_data  out  DATA_W  to FIFO w_data.
- fifo_r_enable  in  1  copy of the reader's r_enable into the FIFO (monitor only).
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag.
- occupancy  out  CNT_W  tracked FIFO entry count.
- busy  out  1  high while in XFER.

Behaviour:
- Reset (asynchronous, n_rst low):
  - state=IDLE, occupancy=0, rr_ptr=0, remaining=0.
  - All outputs 0.
  - The FIFO shares n_rst, so both clear together. Reset asserted mid-packet abandons the packet; no partial-state recovery.
- Occupancy counter, updated every cycle:
  - wr = fifo_w_enable; rd = fifo_r_enable & ~fifo_empty.
  - occupancy += wr - rd; a simultaneous wr and rd leaves it unchanged.
  - Saturates at 0 and at DEPTH.
  - free = DEPTH - occupancy.
- FSM states: IDLE, XFER.
- IDLE:
  - A source is eligible if req[i]=1, len_i != 0 and len_i <= free.
  - len==0 is never granted and the source stays pending.
  - If both sources are eligible, the winner is the source at rr_ptr.
  - If exactly one is eligible, it wins; an ineligible higher-priority source does not block it.
  - On a win: latch sel and remaining=len_sel, go to XFER.
  - No writes occur in IDLE.
- XFER, every cycle:
  - fifo_w_enable=1, fifo_w_data=data_sel, byte_ack[sel]=1, remaining-=1.
  - When remaining==1: pkt_done[sel]=1, rr_ptr=~sel, return to IDLE.
- Latency:
  - Grant decision in cycle N; first byte written in N+1; last byte in N+len.
  - One IDLE cycle separates consecutive packets.
- Outputs are registered or derived only from state, sel, and the data inputs. fifo_w_data is a mux of data0/data1 on the latched sel.
- Reservation guarantees fifo_full is never 1 during XFER. A write with fifo_full=1 is a design error: assertion only, no RTL recovery.
- The requester must not change len_i while req is high.

Decomposition:
- Package nd_sched_pkg:
  - state_t enum {IDLE, XFER}.
  - MAX_PKT_LEN=3.
  - USB PID constants used by the bench (ACK=8'hD2, NAK=8'h5A, STALL=8'h1E).
- One sub-module: nd_occ_counter, the occupancy up/down counter with saturation.
- Arbitration and FSM stay in the top module.

Test Plan:
- Reset then req=2'b10, len1=1, data1=8'hD2 -> fifo_w_enable high for exactly 1 cycle, one cycle after req; byte D2 written; pkt_done=2'b10 on the same cycle; occupancy=1.
- req=2'b01, len0=3, bytes 69/12/34 -> three consecutive writes 69,12,34; byte_ack[0] each cycle; pkt_done[0] on the third; occupancy=3.
- req=2'b11 held, len0=len1=1, repeated 4 packets -> grant order 0,1,0,1; each packet separated by one IDLE cycle.
- Prefill 49 entries; req0 len=3 and req1 len=1 -> source 1 granted regardless of rr_ptr, occupancy=50; source 0 waits. Then pulse fifo_r_enable twice -> occupancy 48, source 0 still waits. A third read -> 47, source 0 granted.
- Simultaneous fifo_r_enable and write during XFER with occupancy=10 -> occupancy stays 10. fifo_r_enable while fifo_empty=1 -> occupancy stays 0.
- Assert n_rst low in the middle of a 3-byte packet -> all outputs 0 immediately; occupancy=0; after release, a new req is granted normally.

Source files
------------

// File: rtl/nd_sched_pkg.sv
// Shared types and constants for the non-data packet write scheduler.
package nd_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int unsigned MAX_PKT_LEN = 3;

    // Handshake PIDs produced by the local handshake generator
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

endpackage

// File: rtl/nd_occ_counter.sv
// Up/down FIFO occupancy tracker, saturating at 0 and DEPTH.
module nd_occ_counter #(
    parameter int unsigned DEPTH = 50,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr,
    input  logic             rd,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (wr && !rd) begin
            if (count_q != CNT_W'(DEPTH)) count_d = count_q + 1'b1;
        end else if (rd && !wr) begin
            if (count_q != '0) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/nd_pkt_sched.sv
// Two-source packet write scheduler: grants a whole packet only when the FIFO
// has room for it, then streams its bytes back-to-back.
module nd_pkt_sched
    import nd_sched_pkg::*;
#(
    parameter int unsigned DEPTH  = 50,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LEN_W  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [1:0]        req,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic [1:0]        byte_ack,
    output logic [1:0]        pkt_done,
    output logic              fifo_w_enable,
    output logic [DATA_W-1:0] fifo_w_data,
    input  logic              fifo_r_enable,
    input  logic              fifo_empty,
    input  logic              fifo_full,
    output logic [CNT_W-1:0]  occupancy,
    output logic              busy
);

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             rr_q, rr_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] free;
    logic [1:0]       elig;
    logic             last;

    nd_occ_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .clk   (clk),
        .n_rst (n_rst),
        .wr    (fifo_w_enable),
        .rd    (fifo_r_enable & ~fifo_empty),
        .count (occupancy)
    );

    assign free = CNT_W'(DEPTH) - occupancy;

    // Reserve room for the whole packet up front so packets never split
    assign elig[0] = req[0] && (len0 != '0) && (CNT_W'(len0) <= free);
    assign elig[1] = req[1] && (len1 != '0) && (CNT_W'(len1) <= free);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    sel_d   = (&elig) ? rr_q : elig[1];
                    rem_d   = sel_d ? len1 : len0;
                    state_d = XFER;
                end
            end
            XFER: begin
                rem_d = rem_q - 1'b1;
                if (rem_q == LEN_W'(1)) begin
                    rr_d    = ~sel_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            rem_q   <= rem_d;
        end
    end

    assign busy          = (state_q == XFER);
    assign last          = busy && (rem_q == LEN_W'(1));
    assign fifo_w_enable = busy;
    assign fifo_w_data   = busy ? (sel_q ? data1 : data0) : '0;
    assign byte_ack      = busy ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign pkt_done      = last ? byte_ack : 2'b00;

    no_write_when_full: assert property (
        @(posedge clk) disable iff (!n_rst) fifo_w_enable |-> !fifo_full
    );

endmodule

// File: tb/tb_nd_pkt_sched.sv
// Self-checking bench for nd_pkt_sched with a FIFO count model and byte scoreboard.
module tb_nd_pkt_sched;
    import nd_sched_pkg::*;

    localparam int unsigned DEPTH  = 50;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LEN_W  = 2;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic       src;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic              clk;
    logic              n_rst;
    logic [1:0]        req;
    logic [LEN_W-1:0]  len0, len1;
    logic [DATA_W-1:0] data0, data1;
    logic [1:0]        byte_ack, pkt_done;
    logic              fifo_w_enable;
    logic [DATA_W-1:0] fifo_w_data;
    logic              fifo_r_enable, fifo_empty, fifo_full;
    logic [CNT_W-1:0]  occupancy;
    logic              busy;

    nd_pkt_sched #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .req           (req),
        .len0          (len0),
        .len1          (len1),
        .data0         (data0),
        .data1         (data1),
        .byte_ack      (byte_ack),
        .pkt_done      (pkt_done),
        .fifo_w_enable (fifo_w_enable),
        .fifo_w_data   (fifo_w_data),
        .fifo_r_enable (fifo_r_enable),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .occupancy     (occupancy),
        .busy          (busy)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         mcount   = 0;
    int         npk[2];
    int         s;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    exp_t       sb[$];
    int         wr_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        data0      = (q0.size() > 0) ? q0[0] : 8'h00;
        data1      = (q1.size() > 0) ? q1[0] : 8'h00;
        fifo_empty = (mcount == 0);
        fifo_full  = (mcount >= int'(DEPTH));
    endtask

    // One clock: check outputs at negedge, then update sources and FIFO model after the edge
    task automatic tick();
        logic [1:0] ack, done;
        logic       wr, rd;
        exp_t       e;
        @(negedge clk);
        check_val("occ_track", 32'(occupancy), 32'(mcount));
        wr   = fifo_w_enable;
        ack  = byte_ack;
        done = pkt_done;
        rd   = fifo_r_enable && (mcount > 0);
        if (wr) begin
            wr_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check_val("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_val("w_data", 32'(fifo_w_data), 32'(e.data));
                check_val("byte_ack", 32'(byte_ack), e.src ? 32'd2 : 32'd1);
                check_val("pkt_done", 32'(pkt_done), e.last ? (e.src ? 32'd2 : 32'd1) : 32'd0);
            end
        end else begin
            check_val("idle_outs", {28'd0, byte_ack, pkt_done}, 32'd0);
        end
        @(posedge clk);
        #1;
        cyc++;
        mcount = mcount + (wr ? 1 : 0) - (rd ? 1 : 0);
        if (ack[0] && q0.size() > 0) q0.delete(0);
        if (ack[1] && q1.size() > 0) q1.delete(0);
        for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
                npk[i]--;
                if (npk[i] <= 0) req[i] = 1'b0;
            end
        end
        fifo_r_enable = 1'b0;
        refresh();
    endtask

    task automatic add_pkt(input int src, input int len, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] b[3];
        exp_t       e;
        b[0] = b0;
        b[1] = b1;
        b[2] = b2;
        for (int k = 0; k < len; k++) begin
            if (src == 0) q0.push_back(b[k]);
            else          q1.push_back(b[k]);
            e.src  = (src != 0);
            e.data = b[k];
            e.last = (k == len - 1);
            sb.push_back(e);
        end
        npk[src]++;
        req[src] = 1'b1;
        if (src == 0) len0 = LEN_W'(len);
        else          len1 = LEN_W'(len);
        refresh();
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (req != 2'b00 && n < budget) begin
            tick();
            n++;
        end
        if (req != 2'b00) check_val("timeout", 32'(req), 32'd0);
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (!busy && n < budget) begin
            tick();
            n++;
        end
        check_val("got_busy", 32'(busy), 32'd1);
    endtask

    task automatic clear_model();
        req           = 2'b00;
        fifo_r_enable = 1'b0;
        q0.delete();
        q1.delete();
        sb.delete();
        wr_cyc.delete();
        npk[0] = 0;
        npk[1] = 0;
        mcount = 0;
        refresh();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        n_rst = 1'b0;
        len0  = '0;
        len1  = '0;
        clear_model();
        #2;
        check_val("rst_w_en", 32'(fifo_w_enable), 32'd0);
        check_val("rst_w_data", 32'(fifo_w_data), 32'd0);
        check_val("rst_ack_done", {28'd0, byte_ack, pkt_done}, 32'd0);
        check_val("rst_occ", 32'(occupancy), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        do_reset();

        // Single-byte handshake from source 1
        s = cyc;
        add_pkt(1, 1, PID_ACK, 8'h00, 8'h00);
        wait_done(20);
        check_val("t1_writes", 32'(wr_cyc.size()), 32'd1);
        check_val("t1_latency", 32'((wr_cyc.size() > 0) ? wr_cyc[0] - s : -1), 32'd1);
        check_val("t1_occ", 32'(occupancy), 32'd1);

        // Three-byte packet from source 0
        do_reset();
        add_pkt(0, 3, 8'h69, 8'h12, 8'h34);
        wait_done(20);
        check_val("t2_writes", 32'(wr_cyc.size()), 32'd3);
        check_val("t2_span", 32'((wr_cyc.size() == 3) ? wr_cyc[2] - wr_cyc[0] : -1), 32'd2);
        check_val("t2_occ", 32'(occupancy), 32'd3);

        // Both held: round-robin 0,1,0,1 with one idle cycle between packets
        do_reset();
        add_pkt(0, 1, 8'hA0, 8'h00, 8'h00);
        add_pkt(1, 1, 8'hB0, 8'h00, 8'h00);
        add_pkt(0, 1, 8'hA1, 8'h00, 8'h00);
        add_pkt(1, 1, 8'hB1, 8'h00, 8'h00);
        wait_done(40);
        check_val("t3_writes", 32'(wr_cyc.size()), 32'd4);
        for (int k = 1; k < wr_cyc.size(); k++) begin
            check_val("t3_gap", 32'(wr_cyc[k] - wr_cyc[k-1]), 32'd2);
        end

        // Nearly full: only the packet that fits is granted
        do_reset();
        for (int k = 0; k < 16; k++) add_pkt(0, 3, 8'(k), 8'(k + 64), 8'(k + 128));
        wait_done(200);
        add_pkt(1, 1, PID_NAK, 8'h00, 8'h00);
        wait_done(20);
        check_val("t4_prefill", 32'(occupancy), 32'd49);
        wr_cyc.delete();
        add_pkt(1, 1, PID_STALL, 8'h00, 8'h00);
        add_pkt(0, 3, 8'h55, 8'h66, 8'h77);
        for (int n = 0; n < 20 && req[1]; n++) tick();
        repeat (4) tick();
        check_val("t4_full_occ", 32'(occupancy), 32'd50);
        check_val("t4_src0_wait", 32'(req[0]), 32'd1);
        check_val("t4_one_write", 32'(wr_cyc.size()), 32'd1);
        repeat (2) begin
            fifo_r_enable = 1'b1;
            tick();
        end
        check_val("t4_occ48", 32'(occupancy), 32'd48);
        repeat (4) tick();
        check_val("t4_still_wait", 32'(req[0]), 32'd1);
        check_val("t4_occ48_hold", 32'(occupancy), 32'd48);
        fifo_r_enable = 1'b1;
        tick();
        check_val("t4_occ47", 32'(occupancy), 32'd47);
        wait_done(20);
        check_val("t4_final_occ", 32'(occupancy), 32'd50);
        check_val("t4_writes", 32'(wr_cyc.size()), 32'd4);

        // Read coinciding with a write leaves occupancy unchanged
        do_reset();
        for (int k = 0; k < 5; k++) add_pkt(1, 2, 8'(k + 16), 8'(k + 32), 8'h00);
        wait_done(50);
        check_val("t5_prefill", 32'(occupancy), 32'd10);
        add_pkt(0, 3, 8'hC1, 8'hC2, 8'hC3);
        wait_busy(10);
        fifo_r_enable = 1'b1;
        tick();
        check_val("t5_rw_same", 32'(occupancy), 32'd10);
        wait_done(20);
        check_val("t5_after", 32'(occupancy), 32'd12);
        do_reset();
        fifo_r_enable = 1'b1;
        tick();
        check_val("t5_empty_rd", 32'(occupancy), 32'd0);

        // Reset in the middle of a packet
        do_reset();
        add_pkt(0, 3, 8'hE1, 8'hE2, 8'hE3);
        wait_busy(10);
        tick();
        n_rst = 1'b0;
        #1;
        check_val("t6_w_en", 32'(fifo_w_enable), 32'd0);
        check_val("t6_w_data", 32'(fifo_w_data), 32'd0);
        check_val("t6_ack_done", {28'd0, byte_ack, pkt_done}, 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        check_val("t6_occ", 32'(occupancy), 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        add_pkt(1, 2, 8'hF1, 8'hF2, 8'h00);
        wait_done(20);
        check_val("t6_regrant_occ", 32'(occupancy), 32'd2);
        check_val("sb_left", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
